// File: rtl/rv32i_decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and execute.
// The master side drives instructions in and accepts bundles; the slave is the decode stage.
interface rv32i_decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [3:0]  out_alu_ctrl;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [1:0]  out_a_sel;
   logic        out_b_sel;
   logic [2:0]  out_funct3;
   logic        out_reg_we;
   logic        out_mem_re;
   logic        out_mem_we;
   logic        out_is_branch;
   logic        out_is_jal;
   logic        out_is_jalr;
   logic        out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_alu_ctrl, out_imm, out_rs1, out_rs2, out_rd,
             out_a_sel, out_b_sel, out_funct3, out_reg_we, out_mem_re, out_mem_we,
             out_is_branch, out_is_jal, out_is_jalr, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_alu_ctrl, out_imm, out_rs1, out_rs2, out_rd,
             out_a_sel, out_b_sel, out_funct3, out_reg_we, out_mem_re, out_mem_we,
             out_is_branch, out_is_jal, out_is_jalr, out_illegal
   );
endinterface

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: decodes one instruction per cycle into ALU control,
// operand selects and immediate, held in a single-entry output register.
module rv32i_decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                   clk,
   input logic                   rst_n,
   rv32i_decode_stage_if.slave   bus
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [1:0] A_RS1  = 2'd0;
   localparam logic [1:0] A_PC   = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [1:0]  a_sel;
      logic        b_sel;
      logic [2:0]  funct3;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        illegal;
   } bundle_t;

   bundle_t     bundle_d, bundle_q;
   logic        valid_q;
   logic        accept;
   logic        legal_c;
   logic        wb_c;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Shared funct3 map for OP and OP-IMM; alt selects SUB/SRA.
   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_of = ALU_SLL;
         3'b010:  alu_of = ALU_SLT;
         3'b011:  alu_of = ALU_SLTU;
         3'b100:  alu_of = ALU_XOR;
         3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_of = ALU_OR;
         default: alu_of = ALU_AND;
      endcase
   endfunction

   always_comb begin
      bundle_d        = '0;
      legal_c         = 1'b0;
      wb_c            = 1'b0;
      bundle_d.pc     = bus.in_pc;
      bundle_d.rs1    = instr[19:15];
      bundle_d.rs2    = instr[24:20];
      bundle_d.rd     = instr[11:7];
      bundle_d.funct3 = funct3;
      bundle_d.alu    = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            legal_c      = (funct7 == 7'b0000000) ||
                           (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            bundle_d.alu = alu_of(funct3, funct7[5]);
            wb_c         = 1'b1;
         end
         OPC_OPIMM: begin
            case (funct3)
               3'b001:  legal_c = (funct7 == 7'b0000000);
               3'b101:  legal_c = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               default: legal_c = 1'b1;
            endcase
            bundle_d.alu   = alu_of(funct3, (funct3 == 3'b101) && funct7[5]);
            bundle_d.b_sel = 1'b1;
            bundle_d.imm   = imm_i;
            wb_c           = 1'b1;
         end
         OPC_LUI: begin
            legal_c        = 1'b1;
            bundle_d.a_sel = A_ZERO;
            bundle_d.b_sel = 1'b1;
            bundle_d.imm   = imm_u;
            wb_c           = 1'b1;
         end
         OPC_AUIPC: begin
            legal_c        = 1'b1;
            bundle_d.a_sel = A_PC;
            bundle_d.b_sel = 1'b1;
            bundle_d.imm   = imm_u;
            wb_c           = 1'b1;
         end
         OPC_JAL: begin
            legal_c         = 1'b1;
            bundle_d.a_sel  = A_PC;
            bundle_d.b_sel  = 1'b1;
            bundle_d.imm    = imm_j;
            bundle_d.is_jal = 1'b1;
            wb_c            = 1'b1;
         end
         OPC_JALR: begin
            legal_c          = (funct3 == 3'b000);
            bundle_d.a_sel   = A_RS1;
            bundle_d.b_sel   = 1'b1;
            bundle_d.imm     = imm_i;
            bundle_d.is_jalr = 1'b1;
            wb_c             = 1'b1;
         end
         OPC_BRANCH: begin
            legal_c            = (funct3 != 3'b010) && (funct3 != 3'b011);
            bundle_d.alu       = ALU_SUB;
            bundle_d.imm       = imm_b;
            bundle_d.is_branch = 1'b1;
         end
         OPC_LOAD: begin
            legal_c         = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            bundle_d.b_sel  = 1'b1;
            bundle_d.imm    = imm_i;
            bundle_d.mem_re = 1'b1;
            wb_c            = 1'b1;
         end
         OPC_STORE: begin
            legal_c         = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            bundle_d.b_sel  = 1'b1;
            bundle_d.imm    = imm_s;
            bundle_d.mem_we = 1'b1;
         end
         default: legal_c = 1'b0;
      endcase
      // Unsupported encodings still flow through as a harmless ADD with every side effect off.
      if (!legal_c) begin
         bundle_d.alu       = ALU_ADD;
         bundle_d.imm       = '0;
         bundle_d.a_sel     = A_RS1;
         bundle_d.b_sel     = 1'b0;
         bundle_d.mem_re    = 1'b0;
         bundle_d.mem_we    = 1'b0;
         bundle_d.is_branch = 1'b0;
         bundle_d.is_jal    = 1'b0;
         bundle_d.is_jalr   = 1'b0;
         bundle_d.illegal   = 1'b1;
      end
      bundle_d.reg_we = wb_c & legal_c & (bundle_d.rd != 5'd0);
   end

   assign bus.in_ready = rst_n & (~valid_q | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         bundle_q    <= '0;
         bundle_q.pc <= RESET_PC;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         bundle_q <= bundle_d;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_pc        = valid_q ? bundle_q.pc : RESET_PC;
   assign bus.out_alu_ctrl  = bundle_q.alu;
   assign bus.out_imm       = bundle_q.imm;
   assign bus.out_rs1       = bundle_q.rs1;
   assign bus.out_rs2       = bundle_q.rs2;
   assign bus.out_rd        = bundle_q.rd;
   assign bus.out_a_sel     = bundle_q.a_sel;
   assign bus.out_b_sel     = bundle_q.b_sel;
   assign bus.out_funct3    = bundle_q.funct3;
   assign bus.out_reg_we    = bundle_q.reg_we;
   assign bus.out_mem_re    = bundle_q.mem_re;
   assign bus.out_mem_we    = bundle_q.mem_we;
   assign bus.out_is_branch = bundle_q.is_branch;
   assign bus.out_is_jal    = bundle_q.is_jal;
   assign bus.out_is_jalr   = bundle_q.is_jalr;
   assign bus.out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: directed encodings and handshake cases,
// then randomized traffic with flush and reset, checked against a reference decoder.
module tb_rv32i_decode_stage;

   localparam logic [31:0] TB_RESET_PC = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [1:0]  a_sel;
      logic        b_sel;
      logic [2:0]  funct3;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   rv32i_decode_stage_if bus();

   rv32i_decode_stage #(.RESET_PC(TB_RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference decoder: immediates are rebuilt arithmetically from their bit-field weights.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t              e;
      logic signed [31:0] s;
      int                v;
      int                f3;
      logic [6:0]        f7;
      bit                legal;
      bit                wb;
      int                alu_tab [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
      e        = '0;
      s        = ins;
      f3       = int'(ins[14:12]);
      f7       = ins[31:25];
      legal    = 1'b0;
      wb       = 1'b0;
      e.pc     = pc;
      e.rs1    = ins[19:15];
      e.rs2    = ins[24:20];
      e.rd     = ins[11:7];
      e.funct3 = ins[14:12];
      case (ins[6:0])
         7'h33: begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            e.alu = 4'(alu_tab[f3]);
            if (f7 == 7'h20 && f3 == 0) e.alu = 4'd1;
            if (f7 == 7'h20 && f3 == 5) e.alu = 4'd7;
            wb = 1'b1;
         end
         7'h13: begin
            if (f3 == 1)      legal = (f7 == 7'h00);
            else if (f3 == 5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else              legal = 1'b1;
            e.alu = 4'(alu_tab[f3]);
            if (f3 == 5 && f7 == 7'h20) e.alu = 4'd7;
            e.b_sel = 1'b1;
            e.imm   = 32'(s >>> 20);
            wb      = 1'b1;
         end
         7'h37: begin
            legal = 1'b1; e.a_sel = 2'd2; e.b_sel = 1'b1; e.imm = ins & 32'hFFFF_F000; wb = 1'b1;
         end
         7'h17: begin
            legal = 1'b1; e.a_sel = 2'd1; e.b_sel = 1'b1; e.imm = ins & 32'hFFFF_F000; wb = 1'b1;
         end
         7'h6F: begin
            v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                + int'(ins[30:21]) * 2;
            legal = 1'b1; e.a_sel = 2'd1; e.b_sel = 1'b1; e.imm = 32'(v); e.is_jal = 1'b1; wb = 1'b1;
         end
         7'h67: begin
            legal = (f3 == 0); e.b_sel = 1'b1; e.imm = 32'(s >>> 20); e.is_jalr = 1'b1; wb = 1'b1;
         end
         7'h63: begin
            v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                + int'(ins[11:8]) * 2;
            legal = (f3 != 2) && (f3 != 3); e.alu = 4'd1; e.imm = 32'(v); e.is_branch = 1'b1;
         end
         7'h03: begin
            legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.b_sel = 1'b1; e.imm = 32'(s >>> 20); e.mem_re = 1'b1; wb = 1'b1;
         end
         7'h23: begin
            v = int'(s >>> 25) * 32 + int'(ins[11:7]);
            legal = (f3 <= 2); e.b_sel = 1'b1; e.imm = 32'(v); e.mem_we = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e.alu = 4'd0; e.mem_re = 1'b0; e.mem_we = 1'b0;
         e.is_branch = 1'b0; e.is_jal = 1'b0; e.is_jalr = 1'b0; e.illegal = 1'b1;
      end
      e.reg_we = wb && legal && (ins[11:7] != 5'd0);
      return e;
   endfunction

   // Monitor: compares the held bundle every cycle, so hold stability is checked too.
   logic prev_rst_n = 1'b1;
   always @(negedge clk) begin : mon
      exp_t act;
      exp_t exp_b;
      exp_t rst_b;
      logic exp_rdy;
      act = {bus.out_pc, bus.out_alu_ctrl, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
             bus.out_a_sel, bus.out_b_sel, bus.out_funct3, bus.out_reg_we, bus.out_mem_re,
             bus.out_mem_we, bus.out_is_branch, bus.out_is_jal, bus.out_is_jalr, bus.out_illegal};
      rst_b    = '0;
      rst_b.pc = TB_RESET_PC;
      checks++;
      if (!prev_rst_n) begin
         if (bus.out_valid !== 1'b0 || act !== rst_b) begin
            errors++;
            $display("FAIL reset_state: got valid=%b bundle=%h, want valid=0 bundle=%h",
                     bus.out_valid, act, rst_b);
         end
      end else if (q.size() > 0) begin
         exp_b = q[0];
         if (exp_b.illegal) begin
            exp_b.imm   = act.imm;
            exp_b.a_sel = act.a_sel;
            exp_b.b_sel = act.b_sel;
         end
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lost_bundle: got out_valid=%b, want 1 for pc=%h", bus.out_valid, exp_b.pc);
         end else if (act !== exp_b) begin
            errors++;
            $display("FAIL bundle: got %h, want %h", act, exp_b);
         end else if (bus.out_ready) begin
            $display("xfer pc=%h alu=%0d imm=%h illegal=%b", act.pc, act.alu, act.imm, act.illegal);
         end
      end else begin
         if (bus.out_valid !== 1'b0 || bus.out_pc !== TB_RESET_PC) begin
            errors++;
            $display("FAIL idle: got valid=%b pc=%h, want valid=0 pc=%h",
                     bus.out_valid, bus.out_pc, TB_RESET_PC);
         end
      end
      exp_rdy = rst_n && (q.size() == 0 || bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL in_ready: got %b, want %b", bus.in_ready, exp_rdy);
      end
      if (!rst_n || bus.flush) q.delete();
      else if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      prev_rst_n = rst_n;
   end

   task automatic step(output bit acc);
      @(negedge clk);
      #1;
      acc = rst_n && bus.in_valid && bus.in_ready && !bus.flush;
      if (acc) q.push_back(ref_decode(bus.in_instr, bus.in_pc));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(acc);
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      bit acc;
      int n;
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      bus.in_pc    = pc;
      n = 0;
      do begin
         step(acc);
         n++;
      end while (!acc && n < 50);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout: instr=%h not accepted, want accept within 50 cycles", ins);
      end
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] ins;
      logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                                7'h63, 7'h03, 7'h23, 7'h0F, 7'h73, 7'h00};
      int          k;
      ins = $urandom;
      k   = int'($urandom_range(0, 11));
      if (k < 11) ins[6:0] = ops[k];
      case ($urandom_range(0, 2))
         0: ins[31:25] = 7'h00;
         1: ins[31:25] = 7'h20;
         default: ;
      endcase
      return ins;
   endfunction

   initial begin
      bit acc;
      logic [31:0] directed [14] = '{32'h002081B3, 32'h407302B3, 32'h4030D093, 32'hFE208EE3,
                                     32'h00000000, 32'h0000100F, 32'h00000013, 32'h123452B7,
                                     32'h0040006F, 32'h000080E7, 32'h0040A103, 32'h0020A223,
                                     32'h00001067, 32'h0000A063};
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 14; i++) send(directed[i], (i == 3) ? 32'h100 : 32'h1000 + 32'(i * 4));
      idle(2);

      // Downstream stall: second instruction waits three cycles, then flows.
      bus.out_ready = 1'b0;
      send(32'h002081B3, 32'h200);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h407302B3;
      bus.in_pc    = 32'h204;
      for (int i = 0; i < 3; i++) begin
         step(acc);
         checks++;
         if (acc) begin
            errors++;
            $display("FAIL stall_accept: accepted while stalled, want no accept");
         end
      end
      bus.out_ready = 1'b1;
      step(acc);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL stall_release: got no accept, want accept on out_ready=1");
      end
      bus.in_valid = 1'b0;
      idle(2);

      // Flush while holding, with an incoming instruction that must be dropped.
      bus.out_ready = 1'b0;
      send(32'h00500093, 32'h300);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00600113;
      bus.in_pc    = 32'h304;
      bus.flush    = 1'b1;
      idle(1);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      idle(1);
      bus.out_ready = 1'b1;
      idle(2);

      // Reset mid-stream.
      bus.out_ready = 1'b0;
      send(32'h00700193, 32'h400);
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      idle(3);
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      idle(2);

      for (int c = 0; c < 3000; c++) begin
         rst_n         = ($urandom_range(0, 99) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.in_instr  = gen_instr();
         bus.in_pc     = $urandom & 32'hFFFF_FFFC;
         step(acc);
      end
      rst_n         = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
